// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding, address-byte layout and
// bus idle levels. Intended to be reused by the I2C master as well.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      DATA      = 3'd3,
      DATA_ACK  = 3'd4,
      DATA_NACK = 3'd5,
      IGNORE    = 3'd6
   } state_t;

   // R/W flag sits in the LSB of the address byte (0 = write)
   localparam int   RW_BIT   = 0;

   // Released open-drain lines are pulled high
   localparam logic SCL_IDLE = 1'b1;
   localparam logic SDA_IDLE = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives bus events:
// SCL edges plus START/STOP (SDA transitions while SCL is stable high).
module i2c_bus_sync
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda_s,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start_det,
   output logic o_stop_raw
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_hist;
   logic                   r_sda_hist;
   logic                   w_scl;
   logic                   w_sda;

   // Synchroniser chains and one history flop per line; reset to idle-high
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scl_sync <= {SYNC_STAGES{SCL_IDLE}};
         r_sda_sync <= {SYNC_STAGES{SDA_IDLE}};
         r_scl_hist <= SCL_IDLE;
         r_sda_hist <= SDA_IDLE;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
         r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   // SCL must be high in both samples so an SDA change racing an SCL edge
   // is never mistaken for START/STOP.
   assign o_sda_s     = w_sda;
   assign o_scl_rise  =  w_scl & ~r_scl_hist;
   assign o_scl_fall  = ~w_scl &  r_scl_hist;
   assign o_start_det =  w_scl &  r_scl_hist &  r_sda_hist & ~w_sda;
   assign o_stop_raw  =  w_scl &  r_scl_hist & ~r_sda_hist &  w_sda;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C write-only target receiver: address match with ACK, byte reception
// with a valid/ready pulse handshake, NACK on read requests or back-pressure.
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_first,
   output logic       stop_det,
   output logic       busy
);

   state_t     r_state,    w_state_nxt;
   logic [2:0] r_bit_cnt,  w_bit_cnt_nxt;
   logic [6:0] r_shift,    w_shift_nxt;
   logic       r_sda_oe,   w_sda_oe_nxt;
   logic       r_busy,     w_busy_nxt;
   logic [7:0] r_rx_data,  w_rx_data_nxt;
   logic       r_rx_valid, w_rx_valid_nxt;
   logic       r_rx_first, w_rx_first_nxt;
   logic       r_stop_det, w_stop_det_nxt;
   logic       r_armed,    w_armed_nxt;
   logic       r_ack_half, w_ack_half_nxt;

   logic       w_sda_s;
   logic       w_scl_rise;
   logic       w_scl_fall;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_byte;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_scl       (scl),
      .i_sda       (sda),
      .o_sda_s     (w_sda_s),
      .o_scl_rise  (w_scl_rise),
      .o_scl_fall  (w_scl_fall),
      .o_start_det (w_start),
      .o_stop_raw  (w_stop)
   );

   // Open-drain: only ever pull low; reset clears r_sda_oe asynchronously
   assign sda    = r_sda_oe ? 1'b0 : 1'bz;
   assign w_byte = {r_shift, w_sda_s};

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_bit_cnt  <= 3'd7;
         r_shift    <= '0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_first <= 1'b0;
         r_stop_det <= 1'b0;
         r_armed    <= 1'b0;
         r_ack_half <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_busy     <= w_busy_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_rx_first <= w_rx_first_nxt;
         r_stop_det <= w_stop_det_nxt;
         r_armed    <= w_armed_nxt;
         r_ack_half <= w_ack_half_nxt;
      end
   end

   // Next-state logic: STOP beats START beats any SCL-edge activity
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_sda_oe_nxt   = r_sda_oe;
      w_busy_nxt     = r_busy;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_rx_first_nxt = 1'b0;
      w_stop_det_nxt = 1'b0;
      w_armed_nxt    = r_armed;
      w_ack_half_nxt = r_ack_half;

      if (w_stop) begin
         w_state_nxt    = IDLE;
         w_sda_oe_nxt   = 1'b0;
         w_stop_det_nxt = r_busy;
         w_busy_nxt     = 1'b0;
         w_ack_half_nxt = 1'b0;
      end else if (w_start) begin
         w_state_nxt    = ADDR;
         w_bit_cnt_nxt  = 3'd7;
         w_shift_nxt    = '0;
         w_sda_oe_nxt   = 1'b0;
         w_busy_nxt     = 1'b0;
         w_ack_half_nxt = 1'b0;
      end else begin
         case (r_state)
            ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt    = w_byte[6:0];
                  w_bit_cnt_nxt  = r_bit_cnt - 3'd1;
                  w_ack_half_nxt = 1'b0;
                  if (r_bit_cnt == 3'd0) begin
                     if (w_byte[7:1] == SLAVE_ADDR && w_byte[RW_BIT] == 1'b0) begin
                        w_state_nxt = ADDR_ACK;
                        w_busy_nxt  = 1'b1;
                     end else begin
                        w_state_nxt = IGNORE;
                     end
                  end
               end
            end
            // First falling edge starts the ACK drive, second one ends it
            ADDR_ACK, DATA_ACK: begin
               if (w_scl_fall) begin
                  if (!r_ack_half) begin
                     w_sda_oe_nxt   = 1'b1;
                     w_ack_half_nxt = 1'b1;
                  end else begin
                     w_sda_oe_nxt   = 1'b0;
                     w_ack_half_nxt = 1'b0;
                     w_state_nxt    = DATA;
                     w_bit_cnt_nxt  = 3'd7;
                     if (r_state == ADDR_ACK)
                        w_armed_nxt = 1'b1;
                  end
               end
            end
            DATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt    = w_byte[6:0];
                  w_bit_cnt_nxt  = r_bit_cnt - 3'd1;
                  w_ack_half_nxt = 1'b0;
                  if (r_bit_cnt == 3'd0) begin
                     w_rx_data_nxt = w_byte;
                     if (rx_ready) begin
                        w_rx_valid_nxt = 1'b1;
                        w_rx_first_nxt = r_armed;
                        w_armed_nxt    = 1'b0;
                        w_state_nxt    = DATA_ACK;
                     end else begin
                        w_state_nxt    = DATA_NACK;
                     end
                  end
               end
            end
            // SDA stays released through the ACK bit, then go quiet
            DATA_NACK: begin
               if (w_scl_fall) begin
                  if (!r_ack_half) begin
                     w_ack_half_nxt = 1'b1;
                  end else begin
                     w_ack_half_nxt = 1'b0;
                     w_state_nxt    = IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign rx_first = r_rx_first;
   assign stop_det = r_stop_det;
   assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed testbench for i2c_slave_rx: a behavioural I2C master drives
// SCL/SDA, a monitor records rx_valid bytes, stop_det pulses, busy cycles
// and cycles where the target pulls SDA low.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

   localparam int Q = 10;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic       rx_ready = 1'b1;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_first;
   logic       stop_det;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int         v_cnt = 0;
   int         stop_cnt = 0;
   int         busy_cyc = 0;
   int         drive_cnt = 0;
   logic [7:0] v_data  [0:63];
   logic       v_first [0:63];

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave_rx #(
      .SLAVE_ADDR  (7'h50),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl),
      .sda      (sda),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_first (rx_first),
      .stop_det (stop_det),
      .busy     (busy)
   );

   // Record output pulses away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            if (v_cnt < 64) begin
               v_data[v_cnt]  <= rx_data;
               v_first[v_cnt] <= rx_first;
            end
            v_cnt <= v_cnt + 1;
         end
         if (stop_det) stop_cnt <= stop_cnt + 1;
         if (busy)     busy_cyc <= busy_cyc + 1;
      end
   end

   // Count cycles where SDA is low while the master has released it
   always @(posedge clk) begin
      if (rst_n && !m_low && sda === 1'b0) drive_cnt <= drive_cnt + 1;
   end

   task automatic q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      m_low = 1'b0; q();
      scl   = 1'b1; q();
      m_low = 1'b1; q();
      scl   = 1'b0; q();
   endtask

   task automatic bus_stop();
      m_low = 1'b1; q();
      scl   = 1'b1; q();
      m_low = 1'b0; q();
      q();
   endtask

   task automatic send_bit(input logic b);
      m_low = ~b; q();
      scl   = 1'b1; q(); q();
      scl   = 1'b0; q();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic get_ack(output logic a);
      m_low = 1'b0; q();
      scl   = 1'b1; q();
      a     = sda;  q();
      scl   = 1'b0; q();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
      checks++; if (rx_first !== 1'b0) begin errors++; $display("FAIL reset_rx_first got %b exp 0", rx_first); end
      checks++; if (stop_det !== 1'b0) begin errors++; $display("FAIL reset_stop_det got %b exp 0", stop_det); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
      rst_n = 1'b1;
      q();
   endtask

   task automatic test_write_single();
      int v0, s0;
      logic a;
      v0 = v_cnt; s0 = stop_cnt;
      bus_start();
      send_byte(8'hA0); get_ack(a);
      checks++; if (a !== 1'b0)    begin errors++; $display("FAIL single_addr_ack got %b exp 0", a); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_on got %b exp 1", busy); end
      send_byte(8'hC3); get_ack(a);
      checks++; if (a !== 1'b0)    begin errors++; $display("FAIL single_data_ack got %b exp 0", a); end
      bus_stop();
      checks++; if (v_cnt - v0 !== 1)        begin errors++; $display("FAIL single_valid_cnt got %0d exp 1", v_cnt - v0); end
      checks++; if (v_data[v0] !== 8'hC3)    begin errors++; $display("FAIL single_data got %h exp c3", v_data[v0]); end
      checks++; if (v_first[v0] !== 1'b1)    begin errors++; $display("FAIL single_first got %b exp 1", v_first[v0]); end
      checks++; if (stop_cnt - s0 !== 1)     begin errors++; $display("FAIL single_stop_cnt got %0d exp 1", stop_cnt - s0); end
      checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL single_busy_off got %b exp 0", busy); end
   endtask

   task automatic test_ignored(input logic [7:0] addr_byte, input string nm);
      int v0, s0, b0, d0;
      logic a;
      v0 = v_cnt; s0 = stop_cnt; b0 = busy_cyc; d0 = drive_cnt;
      bus_start();
      send_byte(addr_byte); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL %s_addr_nack got %b exp 1", nm, a); end
      send_byte(8'h33); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL %s_data_nack got %b exp 1", nm, a); end
      bus_stop();
      checks++; if (v_cnt - v0 !== 0)         begin errors++; $display("FAIL %s_valid_cnt got %0d exp 0", nm, v_cnt - v0); end
      checks++; if (stop_cnt - s0 !== 0)      begin errors++; $display("FAIL %s_stop_cnt got %0d exp 0", nm, stop_cnt - s0); end
      checks++; if (busy_cyc - b0 !== 0)      begin errors++; $display("FAIL %s_busy_cycles got %0d exp 0", nm, busy_cyc - b0); end
      checks++; if (drive_cnt - d0 !== 0)     begin errors++; $display("FAIL %s_sda_driven got %0d exp 0", nm, drive_cnt - d0); end
   endtask

   task automatic test_multi_byte();
      int v0, s0;
      logic a;
      logic [7:0] exp_d [0:2];
      logic       exp_f [0:2];
      exp_d[0] = 8'h01; exp_d[1] = 8'h80; exp_d[2] = 8'hFF;
      exp_f[0] = 1'b1;  exp_f[1] = 1'b0;  exp_f[2] = 1'b0;
      v0 = v_cnt; s0 = stop_cnt;
      bus_start();
      send_byte(8'hA0); get_ack(a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL multi_addr_ack got %b exp 0", a); end
      for (int i = 0; i < 3; i++) begin
         send_byte(exp_d[i]); get_ack(a);
         checks++; if (a !== 1'b0) begin errors++; $display("FAIL multi_ack%0d got %b exp 0", i, a); end
      end
      bus_stop();
      checks++; if (v_cnt - v0 !== 3) begin errors++; $display("FAIL multi_valid_cnt got %0d exp 3", v_cnt - v0); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (v_data[v0+i] !== exp_d[i])  begin errors++; $display("FAIL multi_data%0d got %h exp %h", i, v_data[v0+i], exp_d[i]); end
         checks++; if (v_first[v0+i] !== exp_f[i]) begin errors++; $display("FAIL multi_first%0d got %b exp %b", i, v_first[v0+i], exp_f[i]); end
      end
      checks++; if (stop_cnt - s0 !== 1) begin errors++; $display("FAIL multi_stop_cnt got %0d exp 1", stop_cnt - s0); end
   endtask

   task automatic test_not_ready();
      int v0, s0;
      logic a;
      v0 = v_cnt; s0 = stop_cnt;
      bus_start();
      send_byte(8'hA0); get_ack(a);
      send_byte(8'h11); get_ack(a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL nrdy_first_ack got %b exp 0", a); end
      rx_ready = 1'b0;
      send_byte(8'h5A); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL nrdy_second_nack got %b exp 1", a); end
      rx_ready = 1'b1;
      send_byte(8'h22); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL nrdy_third_nack got %b exp 1", a); end
      bus_stop();
      checks++; if (v_cnt - v0 !== 1)     begin errors++; $display("FAIL nrdy_valid_cnt got %0d exp 1", v_cnt - v0); end
      checks++; if (v_data[v0] !== 8'h11) begin errors++; $display("FAIL nrdy_data got %h exp 11", v_data[v0]); end
      checks++; if (stop_cnt - s0 !== 1)  begin errors++; $display("FAIL nrdy_stop_cnt got %0d exp 1", stop_cnt - s0); end
   endtask

   task automatic test_repeated_start();
      int v0, s0;
      logic a;
      v0 = v_cnt; s0 = stop_cnt;
      bus_start();
      send_byte(8'hA0); get_ack(a);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus_start();
      send_byte(8'hA0); get_ack(a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b exp 0", a); end
      send_byte(8'h77); get_ack(a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_data_ack got %b exp 0", a); end
      bus_stop();
      checks++; if (v_cnt - v0 !== 1)     begin errors++; $display("FAIL rs_valid_cnt got %0d exp 1", v_cnt - v0); end
      checks++; if (v_data[v0] !== 8'h77) begin errors++; $display("FAIL rs_data got %h exp 77", v_data[v0]); end
      checks++; if (v_first[v0] !== 1'b1) begin errors++; $display("FAIL rs_first got %b exp 1", v_first[v0]); end
      checks++; if (stop_cnt - s0 !== 1)  begin errors++; $display("FAIL rs_stop_cnt got %0d exp 1", stop_cnt - s0); end
   endtask

   task automatic test_reset_mid_ack();
      bus_start();
      send_byte(8'hA0);
      m_low = 1'b0; q();
      scl   = 1'b1; q();
      checks++; if (sda !== 1'b0)  begin errors++; $display("FAIL rst_ack_driven got %b exp 0", sda); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b exp 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL rst_sda_release got %b exp 1", sda); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
      checks++; if (rx_first !== 1'b0) begin errors++; $display("FAIL rst_rx_first got %b exp 0", rx_first); end
      checks++; if (stop_det !== 1'b0) begin errors++; $display("FAIL rst_stop_det got %b exp 0", stop_det); end
      @(negedge clk);
      rst_n = 1'b1;
      q();
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_ignored(8'hA2, "wrong_addr");
      test_ignored(8'hA1, "read_req");
      test_multi_byte();
      test_not_ready();
      test_repeated_start();
      test_reset_mid_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
